mul_div_unit: RTL and testbench

//   Iterative multiply/divide unit in the EX stage; executes MULT, MULTU, DIV, DIVU.

---
 rtl/mul_div_unit.sv | 85 ++++++++
 tb/tb_mul_div_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide (MULT/MULTU/DIV/DIVU) producing HI/LO with a one-cycle write pulse.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, step, prod;
  logic [WIDTH-1:0] m, a_orig, prev_hi, prev_lo, a_mag, b_mag, q, r, res_hi, res_lo;
  logic [WIDTH:0] add_s, rem_sh, diff;
  logic is_div, neg, rneg, dz, accept;
  always_comb begin
    accept = state == IDLE && start && !flush;
    a_mag = (!op[0] && a[WIDTH-1]) ? -a : a;
    b_mag = (!op[0] && b[WIDTH-1]) ? -b : b;
    add_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff = rem_sh - {1'b0, m};
    step = !is_div ? {add_s, acc[WIDTH-1:1]} :
           diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                         {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod = neg ? -step : step;
    q = neg ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    r = rneg ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    // Divide by zero reports the original dividend, bypassing sign fix-up
    res_hi = !is_div ? prod[2*WIDTH-1:WIDTH] : dz ? a_orig : r;
    res_lo = !is_div ? prod[WIDTH-1:0] : dz ? '1 : q;
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = accept ? BUSY : IDLE;
    else if (state == BUSY) state_nxt = flush ? IDLE : (cnt == '0 ? FIX : BUSY);
    else state_nxt = IDLE;
    busy = state != IDLE;
    hilo_we = state == FIX && !flush && !rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        is_div <= op[1];
        neg <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
        rneg <= !op[0] && a[WIDTH-1];
        dz <= op[1] && b == '0;
        a_orig <= a;
        m <= op[1] ? b_mag : a_mag;
        acc <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
        cnt <= CW'(WIDTH - 1);
      end
      if (state == BUSY) begin
        acc <= step;
        cnt <= cnt - 1'b1;
        if (cnt == '0 && !flush) begin
          prev_hi <= hi;
          prev_lo <= lo;
          hi <= res_hi;
          lo <= res_lo;
        end
      end
      // A flush during FIX cancels the write, so restore the previous result
      if (state == FIX && flush) begin
        hi <= prev_hi;
        lo <= prev_lo;
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
  logic clk = 0, rst = 1, start = 0, flush = 0;
  logic [1:0] op_i = 0;
  logic [31:0] a_i = 0, b_i = 0;
  logic busy, hilo_we;
  logic [31:0] hi, lo;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] last = 0;
  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .flush(flush), .busy(busy), .hilo_we(hilo_we), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'd0) return 64'(sa * sb);
    if (op == 2'd1) return {32'd0, a} * {32'd0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (op == 2'd2) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; a_i = a; b_i = b; start = 1;
    @(posedge clk);
    #1 start = 0;
    op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
  endtask
  task automatic await_pulse(input bit inj, output int k, output int nb);
    k = 0; nb = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (busy) nb++;
      if (hilo_we) break;
      if (inj && k == 10) start = 1;
      if (inj && k == 11) start = 0;
    end
    start = 0;
  endtask
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit inj);
    int k, nb;
    issue(op, a, b);
    await_pulse(inj, k, nb);
    last = model(op, a, b);
    chk("latency", 64'(k), 64'd33);
    chk("busy_cycles", 64'(nb), 64'd33);
    chk($sformatf("hilo op%0d a=%h b=%h", op, a, b), {hi, lo}, last);
    @(negedge clk);
    chk("idle_after_fix", {63'd0, busy}, 64'd0);
  endtask
  task automatic abort_check(input bit use_rst);
    int pulses;
    issue(2'd3, $urandom, $urandom_range(1, 1000));
    repeat (10) @(negedge clk);
    if (use_rst) rst = 1; else flush = 1;
    @(posedge clk);
    #1 rst = 0; flush = 0;
    @(negedge clk);
    chk(use_rst ? "rst_busy" : "flush_busy", {63'd0, busy}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (hilo_we) pulses++;
    end
    if (use_rst) last = 0;
    chk(use_rst ? "rst_pulses" : "flush_pulses", 64'(pulses), 64'd0);
    chk(use_rst ? "rst_hilo" : "flush_hilo", {hi, lo}, last);
  endtask
  initial begin
    logic [1:0] op;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_we", {63'd0, hilo_we}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    rst = 0;
    @(negedge clk);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_ones", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'd3, 32'd7, 32'd2, 0);
    chk("divu_small", {hi, lo}, 64'h0000_0001_0000_0003);
    do_op(2'd3, 32'h0000_1234, 32'd0, 0);
    chk("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd0, 0);
    chk("div_zero", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op(2'd1, 32'h1357_9BDF, 32'h2468_ACE0, 1);
    do_op(2'd0, 32'h0000_0007, 32'hFFFF_FFF8, 0);
    abort_check(0);
    start = 1; flush = 1;
    @(posedge clk);
    #1 start = 0; flush = 0;
    @(negedge clk);
    chk("start_flush_idle", {63'd0, busy}, 64'd0);
    abort_check(1);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      do_op(op, a, b, i % 5 == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
